sand_sweep: RTL

- Frame-level sequencer that drives the combinational sand_update cell updater against the sand framebuffer RAM.
- On each start pulse it sweeps the screen bottom-up and left-to-right. For each word pair it reads the region word (row r) and the floor word (row r+1), presents them to sand_update with the edge flags, and writes both updated words back.
- Sits between the frame-tick logic and the framebuffer's shared memory port, which is arbitrated by a req/gnt pair.

---
 rtl/sand_pkg.sv | 23 ++
 rtl/sand_update.sv | 57 +++++
 rtl/sand_sweep.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sand_pkg.sv
// Shared types for the sand framebuffer sweep: pixel encoding and sequencer states.
package sand_pkg;

  typedef enum logic [1:0] {
    AIR     = 2'b00,
    SAND    = 2'b01,
    SAND_AM = 2'b10,
    WALL    = 2'b11
  } cell_t;

  localparam int PIX_PER_WORD = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_R,
    RD_F,
    WAIT,
    WR_R,
    WR_F,
    DONE
  } state_t;

endpackage

// File: rtl/sand_update.sv
// Combinational cell updater for one region word sitting directly above one floor word.
// Pixel i occupies bits [2i+1:2i]; pixel 15 is the leftmost on screen.
module sand_update
  import sand_pkg::*;
(
  input  logic [31:0] region,
  input  logic [31:0] floor,
  input  logic        screenbegin,
  input  logic        screenend,
  input  logic        screenbottom,
  output logic [31:0] new_region,
  output logic [31:0] new_floor
);

  logic [31:0] rw;
  logic [31:0] fw;
  int          ri;
  int          li;
  logic        hug;

  always_comb begin
    rw  = region;
    fw  = floor;
    ri  = 0;
    li  = 0;
    hug = 1'b0;
    // The bottom row is never a region, so its "already moved" marks are cleared here.
    if (screenbottom) begin
      for (int i = 0; i < PIX_PER_WORD; i++) begin
        if (fw[2*i +: 2] == SAND_AM) fw[2*i +: 2] = SAND;
      end
    end
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      ri  = (i > 0) ? i - 1 : i;
      li  = (i < PIX_PER_WORD - 1) ? i + 1 : i;
      // A grain touching a side wall of the screen does not slide away from it.
      hug = ((i == PIX_PER_WORD - 1) && screenbegin) || ((i == 0) && screenend);
      if (rw[2*i +: 2] == SAND_AM) begin
        rw[2*i +: 2] = SAND;
      end else if (rw[2*i +: 2] == SAND) begin
        if (fw[2*i +: 2] == AIR) begin
          rw[2*i +: 2] = AIR;
          fw[2*i +: 2] = SAND_AM;
        end else if (!hug && (ri != i) && (fw[2*ri +: 2] == AIR)) begin
          rw[2*i +: 2]  = AIR;
          fw[2*ri +: 2] = SAND_AM;
        end else if (!hug && (li != i) && (fw[2*li +: 2] == AIR)) begin
          rw[2*i +: 2]  = AIR;
          fw[2*li +: 2] = SAND_AM;
        end
      end
    end
    new_region = rw;
    new_floor  = fw;
  end

endmodule

// File: rtl/sand_sweep.sv
// Frame sequencer: walks region/floor word pairs bottom-up, left-to-right, through
// sand_update over a req/gnt-arbitrated single memory port.
module sand_sweep
  import sand_pkg::*;
#(
  parameter int WIDTH_WORDS = 40,
  parameter int HEIGHT      = 480,
  parameter int AW          = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int RW = $clog2(HEIGHT);
  localparam int CW = (WIDTH_WORDS > 1) ? $clog2(WIDTH_WORDS) : 1;
  localparam logic [RW-1:0] ROW_TOP  = RW'(HEIGHT - 2);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH_WORDS - 1);

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [31:0]   region_q, region_d;
  logic [31:0]   floor_q, floor_d;
  logic          rd_hit_q, rd_hit_d;

  logic [AW-1:0] addr_r;
  logic [AW-1:0] addr_f;
  logic [31:0]   new_region;
  logic [31:0]   new_floor;

  assign addr_r = AW'(row_q) * AW'(WIDTH_WORDS) + AW'(col_q);
  assign addr_f = addr_r + AW'(WIDTH_WORDS);

  sand_update u_upd (
    .region       (region_q),
    .floor        (floor_q),
    .screenbegin  (col_q == '0),
    .screenend    (col_q == COL_LAST),
    .screenbottom (row_q == ROW_TOP),
    .new_region   (new_region),
    .new_floor    (new_floor)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      region_q <= '0;
      floor_q  <= '0;
      rd_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      region_q <= region_d;
      floor_q  <= floor_d;
      rd_hit_q <= rd_hit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    region_d  = region_q;
    floor_d   = floor_q;
    rd_hit_d  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          row_d   = ROW_TOP;
          col_d   = '0;
          state_d = RD_R;
        end
      end
      RD_R: begin
        mem_req  = 1'b1;
        mem_addr = addr_r;
        if (mem_gnt) begin
          rd_hit_d = 1'b1;
          state_d  = RD_F;
        end
      end
      RD_F: begin
        mem_req  = 1'b1;
        mem_addr = addr_f;
        // Region data is only on the bus in the cycle right after its read was granted.
        if (rd_hit_q) region_d = mem_rdata;
        if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        floor_d = mem_rdata;
        state_d = WR_R;
      end
      WR_R: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_r;
        mem_wdata = new_region;
        if (mem_gnt) state_d = WR_F;
      end
      WR_F: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_f;
        mem_wdata = new_floor;
        if (mem_gnt) begin
          if (col_q != COL_LAST) begin
            col_d   = col_q + CW'(1);
            state_d = RD_R;
          end else if (row_q != '0) begin
            col_d   = '0;
            row_d   = row_q - RW'(1);
            state_d = RD_R;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule
